// File: rtl/cordic_engine.sv
// Iterative multi-mode CORDIC engine: sine/cosine, raw rotation and vectoring
// (magnitude/atan2), one transaction at a time behind valid/ready handshakes.
module cordic_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_z,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y,
  output logic [WIDTH-1:0] o_z
);
  localparam int unsigned XW  = WIDTH + 2;
  localparam int unsigned CW  = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned TAB = 2 ** CW;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_VECTOR = 2'd2;
  localparam logic [WIDTH-1:0] HALF_TURN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic real pow2(input int unsigned e);
    real p;
    p = 1.0;
    for (int unsigned k = 0; k < e; k++) p = p * 2.0;
    return p;
  endfunction

  // atan(2^-i) in binary angle units; Taylor series converges fast for i >= 1
  function automatic int atan_units(input int unsigned i);
    real t, term, acc;
    if (i == 0) begin
      acc = 0.78539816339744831;
    end else begin
      t    = 1.0 / pow2(i);
      term = t;
      acc  = 0.0;
      for (int k = 0; k < 40; k++) begin
        acc  = acc + (((k % 2) == 0) ? term : -term) / (2.0 * k + 1.0);
        term = term * t * t;
      end
    end
    return $rtoi(acc * pow2(WIDTH) / 6.283185307179586 + 0.5);
  endfunction

  function automatic int kinv_units();
    real p, s;
    p = 1.0;
    for (int unsigned i = 0; i < ITER; i++) p = p * (1.0 + 1.0 / pow2(2 * i));
    s = 1.0;
    for (int k = 0; k < 40; k++) s = 0.5 * (s + p / s);
    return $rtoi(pow2(WIDTH - 2) / s + 0.5);
  endfunction

  localparam logic [XW-1:0] KINV = XW'(kinv_units());

  function automatic logic [WIDTH-1:0] sat(input logic [XW-1:0] v);
    if (v[XW-1:WIDTH-1] == '0 || v[XW-1:WIDTH-1] == '1) return v[WIDTH-1:0];
    return v[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, ITERATE = 2'd1, DONE = 2'd2} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        cnt;
  logic signed [XW-1:0] x, y, x_ld, y_ld, x_it, y_it, x_sh, y_sh;
  logic [WIDTH-1:0]     z, z_ld, z_it;
  logic                 vec, zero_vec, is_vec, accept, last, d_pos;
  logic [WIDTH-1:0]     atan_tab [TAB];

  for (genvar g = 0; g < TAB; g++) begin : g_atan
    if (g < ITER) begin : g_used
      assign atan_tab[g] = WIDTH'(atan_units(g));
    end else begin : g_pad
      assign atan_tab[g] = '0;
    end
  end

  assign o_ready = (state == IDLE);
  assign accept  = i_valid & o_ready;
  assign last    = (cnt == CW'(ITER - 1));

  always_comb begin : fsm_next
    state_next = state;
    case (state)
      IDLE:    if (accept)  state_next = ITERATE;
      ITERATE: if (last)    state_next = DONE;
      DONE:    if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand load with quadrant pre-rotation by pi into the CORDIC convergence range
  always_comb begin : load_calc
    is_vec = (i_mode == MODE_VECTOR);
    x_ld   = KINV;
    y_ld   = '0;
    z_ld   = is_vec ? '0 : i_z;
    if (is_vec || i_mode == MODE_ROTATE) begin
      x_ld = {{2{i_x[WIDTH-1]}}, i_x};
      y_ld = {{2{i_y[WIDTH-1]}}, i_y};
    end
    if (is_vec ? i_x[WIDTH-1] : (i_z[WIDTH-1] ^ i_z[WIDTH-2])) begin
      x_ld = -x_ld;
      y_ld = -y_ld;
      z_ld = z_ld + HALF_TURN;
    end
  end

  always_comb begin : iter_calc
    x_sh  = x >>> cnt;
    y_sh  = y >>> cnt;
    d_pos = vec ? y[XW-1] : ~z[WIDTH-1];
    if (d_pos) begin
      x_it = x - y_sh;
      y_it = y + x_sh;
      z_it = z - atan_tab[cnt];
    end else begin
      x_it = x + y_sh;
      y_it = y - x_sh;
      z_it = z + atan_tab[cnt];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin : datapath
    if (!reset_n) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      cnt      <= '0;
      vec      <= 1'b0;
      zero_vec <= 1'b0;
      o_valid  <= 1'b0;
      o_x      <= '0;
      o_y      <= '0;
      o_z      <= '0;
    end else begin
      o_valid <= (state_next == DONE);
      if (accept) begin
        x        <= x_ld;
        y        <= y_ld;
        z        <= z_ld;
        cnt      <= '0;
        vec      <= is_vec;
        zero_vec <= is_vec && (i_x == '0) && (i_y == '0);
      end else if (state == ITERATE) begin
        x   <= x_it;
        y   <= y_it;
        z   <= z_it;
        cnt <= cnt + CW'(1);
        if (last) begin
          o_x <= sat(x_it);
          o_y <= sat(y_it);
          o_z <= zero_vec ? '0 : z_it;
        end
      end
    end
  end
endmodule

// File: tb/tb_cordic_engine.sv
// Scoreboard bench for cordic_engine: random transactions against a floating-point
// reference model, backpressure, mid-operation reset and a 12-bit/10-iteration instance.
module tb_cordic_engine;
  localparam int W = 16, N = 14, W2 = 12, N2 = 10;
  localparam int SINCOS = 0, ROTATE = 1, VECTOR = 2;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         i_valid, o_ready, o_valid, i_ready = 1'b0;
  logic [1:0]   i_mode;
  logic [W-1:0] i_x, i_y, i_z, o_x, o_y, o_z;
  logic          v2_valid, r2_ready, ov2_valid, r2_in_ready;
  logic [1:0]    m2_mode;
  logic [W2-1:0] x2_in, y2_in, z2_in, x2_out, y2_out, z2_out;

  cordic_engine #(.WIDTH(W), .ITER(N)) dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
    .i_x(i_x), .i_y(i_y), .i_z(i_z), .o_valid(o_valid), .i_ready(i_ready),
    .o_x(o_x), .o_y(o_y), .o_z(o_z));

  cordic_engine #(.WIDTH(W2), .ITER(N2)) dut2 (
    .clk(clk), .reset_n(reset_n), .i_valid(v2_valid), .o_ready(r2_ready), .i_mode(m2_mode),
    .i_x(x2_in), .i_y(y2_in), .i_z(z2_in), .o_valid(ov2_valid), .i_ready(r2_in_ready),
    .o_x(x2_out), .o_y(y2_out), .o_z(z2_out));

  typedef struct {int ex; int ey; int ez; int tx; int ty; int tz; int t0;} exp_t;
  exp_t q[$];
  exp_t q2[$];
  exp_t mon_e, mon2_e;
  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic void check(string name, int act, int exp, int tol, int modw);
    int d;
    d = act - exp;
    if (modw > 0) begin
      d = d & ((1 << modw) - 1);
      if (d >= (1 << (modw - 1))) d = d - (1 << modw);
    end
    checks++;
    if (d < -tol || d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endfunction

  // Ideal math: SINCOS is unit-gain, ROTATE/VECTOR carry the CORDIC gain
  function automatic exp_t model(int w, int n, int mode, int x, int y, int z, int t0);
    exp_t e;
    real one, full, k, a, xr, yr, g;
    one  = real'(longint'(1) << (w - 2));
    full = real'(longint'(1) << w);
    k = 1.0;
    for (int i = 0; i < n; i++) k = k * $sqrt(1.0 + 1.0 / real'(longint'(1) << (2 * i)));
    e = '{0, 0, 0, 0, 0, 0, t0};
    if (mode == VECTOR) begin
      if (x != 0 || y != 0) begin
        xr = real'(x);
        yr = real'(y);
        e.ex = rnd(k * $sqrt(xr * xr + yr * yr));
        e.ez = rnd($atan2(yr, xr) * full / (2.0 * PI));
        e.tx = 16; e.ty = 16; e.tz = 8;
      end
    end else begin
      a = real'(z) * 2.0 * PI / full;
      if (mode == ROTATE) begin
        xr = real'(x); yr = real'(y); g = k;
        e.tx = 16; e.ty = 16;
      end else begin
        xr = one; yr = 0.0; g = 1.0;
        e.tx = 6; e.ty = 6;
      end
      e.ex = rnd(g * (xr * $cos(a) - yr * $sin(a)));
      e.ey = rnd(g * (xr * $sin(a) + yr * $cos(a)));
      e.tz = 4;
    end
    return e;
  endfunction

  task automatic send(int mode, int x, int y, int z, int tx, int ty, int tz);
    exp_t e;
    int g = 0;
    @(negedge clk);
    while (!o_ready && g < 200) begin @(negedge clk); g++; end
    if (!o_ready) begin fail("accept_timeout"); return; end
    i_mode = 2'(mode); i_x = W'(x); i_y = W'(y); i_z = W'(z); i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    e = model(W, N, mode, x, y, z & ((1 << W) - 1), cyc);
    if (tx >= 0) e.tx = tx;
    if (ty >= 0) e.ty = ty;
    if (tz >= 0) e.tz = tz;
    q.push_back(e);
  endtask

  task automatic send2(int z, int t);
    exp_t e;
    int g = 0;
    @(negedge clk);
    while (!r2_ready && g < 200) begin @(negedge clk); g++; end
    if (!r2_ready) begin fail("accept2_timeout"); return; end
    m2_mode = 2'(SINCOS); z2_in = W2'(z); v2_valid = 1'b1;
    @(posedge clk); #1;
    v2_valid = 1'b0;
    e = model(W2, N2, SINCOS, 0, 0, z & ((1 << W2) - 1), cyc);
    e.tx = t; e.ty = t;
    q2.push_back(e);
  endtask

  task automatic drain();
    int g = 0;
    while ((q.size() > 0 || q2.size() > 0) && g < 3000) begin @(negedge clk); g++; end
    if (q.size() > 0 || q2.size() > 0) fail("drain_timeout");
  endtask

  // Monitor: latency, hold-while-stalled, transfer compare and post-transfer idle
  logic [W-1:0] hx, hy, hz;
  bit in_done = 0, post = 0, stall = 0, rand_ready = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      in_done = 0;
      post    = 0;
    end else begin
      if (post) begin
        check("valid_low_after_xfer", int'(o_valid), 0, 0, 0);
        check("ready_high_after_xfer", int'(o_ready), 1, 0, 0);
        post = 0;
      end
      if (o_valid) begin
        check("ready_low_in_done", int'(o_ready), 0, 0, 0);
        if (!in_done) begin
          in_done = 1;
          hx = o_x; hy = o_y; hz = o_z;
          if (q.size() == 0) fail("unexpected_output");
          else check("latency", cyc - q[0].t0, N, 0, 0);
        end else begin
          check("hold_x", int'(o_x), int'(hx), 0, 0);
          check("hold_y", int'(o_y), int'(hy), 0, 0);
          check("hold_z", int'(o_z), int'(hz), 0, 0);
        end
      end
      i_ready = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (o_valid && i_ready && q.size() > 0) begin
        mon_e = q.pop_front();
        check("o_x", int'($signed(o_x)), mon_e.ex, mon_e.tx, 0);
        check("o_y", int'($signed(o_y)), mon_e.ey, mon_e.ty, 0);
        check("o_z", int'(o_z), mon_e.ez, mon_e.tz, W);
        in_done = 0;
        post    = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && ov2_valid) begin
      if (q2.size() == 0) fail("unexpected_output2");
      else begin
        mon2_e = q2.pop_front();
        check("latency2", cyc - mon2_e.t0, N2, 0, 0);
        check("o_x2", int'($signed(x2_out)), mon2_e.ex, mon2_e.tx, 0);
        check("o_y2", int'($signed(y2_out)), mon2_e.ey, mon2_e.ty, 0);
      end
    end
  end

  initial begin
    int g, mode, x, y, z;
    real r, ph;
    reset_n = 1'b0; i_valid = 1'b0; i_mode = '0; i_x = '0; i_y = '0; i_z = '0;
    v2_valid = 1'b0; m2_mode = '0; x2_in = '0; y2_in = '0; z2_in = '0; r2_in_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(o_valid), 0, 0, 0);
    check("reset_ready", int'(o_ready), 1, 0, 0);
    check("reset_x", int'(o_x), 0, 0, 0);
    check("reset_y", int'(o_y), 0, 0, 0);
    check("reset_z", int'(o_z), 0, 0, 0);
    reset_n = 1'b1;

    send(SINCOS, 0, 0, 'h1555, 4, 4, -1);
    send(SINCOS, 0, 0, 'h6000, 4, 4, -1);
    send(SINCOS, 0, 0, 'h8000, 4, 4, -1);
    send(3, 0, 0, 'h1555, 4, 4, -1);
    send(VECTOR, 'h2000, 'h2000, 0, 6, 4, 2);
    send(VECTOR, -'h4000, 0, 0, 6, 4, 2);
    send(VECTOR, 0, 0, 0, 0, 0, 0);
    drain();

    // Stall with valid pulses that must be ignored, then release
    stall = 1;
    send(SINCOS, 0, 0, 'h1555, 4, 4, -1);
    g = 0;
    while (!o_valid && g < 100) begin @(negedge clk); g++; end
    if (!o_valid) fail("valid_timeout");
    for (int i = 0; i < 10; i++) begin
      i_valid = i[0]; i_mode = 2'($urandom_range(0, 3)); i_z = W'($urandom);
      @(negedge clk);
    end
    i_valid = 1'b0;
    stall = 0;
    drain();

    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(0, 3));
      r  = 0.5 + 0.45 * real'($urandom_range(0, 1000)) / 1000.0;
      ph = 2.0 * PI * real'($urandom_range(0, 65535)) / 65536.0;
      x  = rnd(r * $cos(ph) * 16384.0);
      y  = rnd(r * $sin(ph) * 16384.0);
      z  = int'($urandom_range(0, 65535));
      send(mode, x, y, z, -1, -1, -1);
    end
    drain();
    rand_ready = 0;

    // Reset during iteration 5: everything clears at once, no output pulse
    send(SINCOS, 0, 0, 'h2000, -1, -1, -1);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midreset_valid", int'(o_valid), 0, 0, 0);
    check("midreset_ready", int'(o_ready), 1, 0, 0);
    check("midreset_x", int'(o_x), 0, 0, 0);
    check("midreset_y", int'(o_y), 0, 0, 0);
    check("midreset_z", int'(o_z), 0, 0, 0);
    q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    send(SINCOS, 0, 0, 'h1555, 4, 4, -1);
    drain();

    send2('h155, 3);
    for (int n = 0; n < 5; n++) send2(int'($urandom_range(0, 4095)), 4);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
